// File: rtl/regfile_scan_reader.sv
// Read-side scan sequencer: walks every register file address, streams each byte
// over valid/ready, then appends one flag byte taken from a snapshot at start.
module regfile_scan_reader #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    regData,
  input  logic          scryIn,
  input  logic          ngtvIn,
  input  logic          zeroIn,
  output logic [pw-1:0] readAddr,
  output logic [7:0]    dataOut,
  output logic          valid,
  input  logic          ready,
  output logic          last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_FLAGS,
    S_DONE
  } state_t;

  localparam logic [pw-1:0] LAST_ADDR = '1;

  state_t        state_q, state_d;
  logic [pw-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [2:0]    flags_q, flags_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;
    flags_d = flags_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          flags_d = {scryIn, ngtvIn, zeroIn};
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end

      // The register file read port is combinational on readAddr, so the byte
      // for the current address is already settled here.
      S_FETCH: begin
        data_d  = regData;
        valid_d = 1'b1;
        state_d = S_SEND;
      end

      S_SEND: begin
        if (valid_q && ready) begin
          if (addr_q == LAST_ADDR) begin
            // Flag beat follows the final register beat back to back; the
            // address is left parked at the top so it never wraps.
            data_d  = {5'b00000, flags_q};
            last_d  = 1'b1;
            state_d = S_FLAGS;
          end else begin
            addr_d  = addr_q + pw'(1);
            valid_d = 1'b0;
            state_d = S_FETCH;
          end
        end
      end

      S_FLAGS: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign readAddr = addr_q;
  assign dataOut  = data_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench for regfile_scan_reader: one instance with pw=3, one with pw=2,
// sharing clock and reset.
module tb_regfile_scan_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- instance A: pw=3 ----------------
  logic       start_a, ready_a, scry_a, ngtv_a, zero_a;
  logic [7:0] regs_a [8];
  logic [7:0] regData_a, dataOut_a;
  logic [2:0] readAddr_a;
  logic       valid_a, last_a, busy_a, done_a;
  assign regData_a = regs_a[readAddr_a];

  regfile_scan_reader #(.pw(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .regData(regData_a),
    .scryIn(scry_a), .ngtvIn(ngtv_a), .zeroIn(zero_a), .readAddr(readAddr_a),
    .dataOut(dataOut_a), .valid(valid_a), .ready(ready_a), .last(last_a),
    .busy(busy_a), .done(done_a)
  );

  // ---------------- instance B: pw=2 ----------------
  logic       start_b, ready_b, scry_b, ngtv_b, zero_b;
  logic [7:0] regs_b [4];
  logic [7:0] regData_b, dataOut_b;
  logic [1:0] readAddr_b;
  logic       valid_b, last_b, busy_b, done_b;
  assign regData_b = regs_b[readAddr_b];

  regfile_scan_reader #(.pw(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .regData(regData_b),
    .scryIn(scry_b), .ngtvIn(ngtv_b), .zeroIn(zero_b), .readAddr(readAddr_b),
    .dataOut(dataOut_b), .valid(valid_b), .ready(ready_b), .last(last_b),
    .busy(busy_b), .done(done_b)
  );

  // Expected beats are packed as {last, readAddr, dataOut}.
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  int beats_a = 0;
  int beats_b = 0;

  bit          stall_a = 0;
  logic [7:0]  hd_a;
  logic [2:0]  ha_a;
  logic        hv_a, hl_a;
  logic [31:0] e_a, e_b;

  // Inputs change at posedge+1, so at the negedge the coming edge's handshake is known.
  always @(negedge clk) begin
    if (reset) begin
      stall_a = 0;
    end else begin
      if (stall_a) begin
        check("hold_data_a", {24'd0, dataOut_a}, {24'd0, hd_a});
        check("hold_addr_a", {29'd0, readAddr_a}, {29'd0, ha_a});
        check("hold_valid_a", {31'd0, valid_a}, {31'd0, hv_a});
        check("hold_last_a", {31'd0, last_a}, {31'd0, hl_a});
      end
      if (valid_a && ready_a) begin
        if (q_a.size() == 0) begin
          check("extra_beat_a", 32'd1, 32'd0);
        end else begin
          e_a = q_a.pop_front();
          check("beat_a", {20'd0, last_a, readAddr_a, dataOut_a}, e_a);
        end
        beats_a++;
      end
      stall_a = valid_a && !ready_a;
      hd_a = dataOut_a;
      ha_a = readAddr_a;
      hv_a = valid_a;
      hl_a = last_a;
    end
  end

  always @(negedge clk) begin
    if (!reset && valid_b && ready_b) begin
      if (q_b.size() == 0) begin
        check("extra_beat_b", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("beat_b", {21'd0, last_b, readAddr_b, dataOut_b}, e_b);
      end
      beats_b++;
    end
  end

  task automatic push_frame_a(input logic [2:0] f);
    for (int i = 0; i < 8; i++) q_a.push_back({20'd0, 1'b0, 3'(i), regs_a[i]});
    q_a.push_back({20'd0, 1'b1, 3'd7, 5'd0, f});
  endtask

  // One frame on A with optional stalls, mid-scan flag change and stray starts.
  task automatic frame_a(input logic [2:0] f0, input int st3, input int stf,
                         input bit chg, input bit extra, input int exp_lat);
    int cyc;
    bit got;
    int s3;
    int sf;
    s3 = st3;
    sf = stf;
    {scry_a, ngtv_a, zero_a} = f0;
    beats_a = 0;
    push_frame_a(f0);
    @(posedge clk); #1;
    start_a = 1'b1;
    ready_a = 1'b1;
    cyc = -1;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(posedge clk); #1;
      cyc++;
      start_a = 1'b0;
      if (extra && ((valid_a && !last_a && beats_a == 2) || last_a || done_a)) start_a = 1'b1;
      if (chg && beats_a >= 4) {scry_a, ngtv_a, zero_a} = 3'b101;
      ready_a = 1'b1;
      if (valid_a && !last_a && beats_a == 3 && s3 > 0) begin
        ready_a = 1'b0;
        s3--;
      end else if (valid_a && last_a && sf > 0) begin
        ready_a = 1'b0;
        sf--;
      end
      if (cyc == 0) begin
        check("busy_rise_a", {31'd0, busy_a}, 32'd1);
        check("first_fetch_valid_a", {31'd0, valid_a}, 32'd0);
      end
      if (cyc == 1) check("first_beat_valid_a", {31'd0, valid_a}, 32'd1);
      if (done_a) got = 1;
    end
    check("done_seen_a", {31'd0, got}, 32'd1);
    if (exp_lat > 0) check("latency_a", cyc, exp_lat);
    check("busy_at_done_a", {31'd0, busy_a}, 32'd1);
    @(posedge clk); #1;
    start_a = 1'b0;
    ready_a = 1'b1;
    check("done_pulse_a", {31'd0, done_a}, 32'd0);
    check("busy_fall_a", {31'd0, busy_a}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("no_refire_a", {30'd0, valid_a, busy_a}, 32'd0);
    end
    check("queue_empty_a", q_a.size(), 32'd0);
    check("beat_count_a", beats_a, 32'd9);
  endtask

  task automatic reset_mid_scan_a();
    bit hit;
    {scry_a, ngtv_a, zero_a} = 3'b011;
    beats_a = 0;
    push_frame_a(3'b011);
    @(posedge clk); #1;
    start_a = 1'b1;
    hit = 0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (valid_a && beats_a == 4) hit = 1;
    end
    check("reach_beat4_a", {31'd0, hit}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("rst_valid_a", {31'd0, valid_a}, 32'd0);
    check("rst_busy_a", {31'd0, busy_a}, 32'd0);
    check("rst_last_a", {31'd0, last_a}, 32'd0);
    check("rst_addr_a", {29'd0, readAddr_a}, 32'd0);
    q_a.delete();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("no_done_after_abort_a", {31'd0, done_a}, 32'd0);
  endtask

  task automatic frame_b();
    int cyc;
    bit got;
    {scry_b, ngtv_b, zero_b} = 3'b111;
    beats_b = 0;
    for (int i = 0; i < 4; i++) q_b.push_back({21'd0, 1'b0, 2'(i), regs_b[i]});
    q_b.push_back({21'd0, 1'b1, 2'd3, 8'h07});
    @(posedge clk); #1;
    start_b = 1'b1;
    ready_b = 1'b1;
    cyc = -1;
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(posedge clk); #1;
      cyc++;
      start_b = 1'b0;
      if (done_b) got = 1;
    end
    check("done_seen_b", {31'd0, got}, 32'd1);
    check("latency_b", cyc, 32'd9);
    @(posedge clk); #1;
    check("busy_fall_b", {31'd0, busy_b}, 32'd0);
    check("queue_empty_b", q_b.size(), 32'd0);
    check("beat_count_b", beats_b, 32'd5);
  endtask

  initial begin
    reset = 1'b1;
    start_a = 1'b0; ready_a = 1'b1; {scry_a, ngtv_a, zero_a} = 3'b000;
    start_b = 1'b0; ready_b = 1'b1; {scry_b, ngtv_b, zero_b} = 3'b000;
    for (int i = 0; i < 8; i++) regs_a[i] = 8'h10 + 8'(i);
    for (int i = 0; i < 4; i++) regs_b[i] = 8'hA0 + 8'(i);
    #1;
    check("reset_addr", {29'd0, readAddr_a}, 32'd0);
    check("reset_data", {24'd0, dataOut_a}, 32'd0);
    check("reset_ctrl", {28'd0, valid_a, last_a, busy_a, done_a}, 32'd0);
    check("reset_ctrl_b", {28'd0, valid_b, last_b, busy_b, done_b}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    frame_a(3'b101, 0, 0, 1'b0, 1'b0, 17);   // full scan, flag byte 0x05
    frame_a(3'b110, 5, 4, 1'b0, 1'b0, 0);    // backpressure on beat 3 and flag beat
    frame_a(3'b010, 0, 0, 1'b1, 1'b0, 17);   // flags change mid-scan, snapshot 0x02
    frame_a(3'b001, 0, 0, 1'b0, 1'b1, 17);   // stray starts in SEND/FLAGS/DONE
    reset_mid_scan_a();
    for (int i = 0; i < 8; i++) regs_a[i] = 8'h5A ^ 8'(i * 17);
    frame_a(3'b100, 0, 0, 1'b0, 1'b0, 17);   // clean frame after abort
    frame_b();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
